// File: rtl/mcu_stripe_scheduler.sv
// Hands full halves of the double-buffered MCU stripe store to the JPEG/DCT consumer,
// one stripe at a time, and tracks frame position, overruns and vsync errors.
module mcu_stripe_scheduler #(
   parameter  int height_pix        = 240,
   parameter  int overrun_cnt_width = 8,
   localparam int num_stripes       = height_pix / 8,
   localparam int idx_width         = (num_stripes > 1) ? $clog2(num_stripes) : 1
) (
   input  logic                         clock,
   input  logic                         nreset,
   input  logic                         hm01b0_vsync,
   input  logic                         ingester_buffer_select,
   input  logic                         stripe_ready,
   input  logic                         stripe_done,
   input  logic                         clear_errors,
   output logic                         stripe_valid,
   output logic                         stripe_buffer,
   output logic [idx_width-1:0]         stripe_index,
   output logic                         last_stripe,
   output logic                         frame_start,
   output logic                         frame_done,
   output logic                         overrun,
   output logic                         sync_error,
   output logic [overrun_cnt_width-1:0] overrun_count
);

   typedef enum logic [1:0] {WAIT_FRAME, FILL, OFFER, BUSY} state_t;

   localparam logic [idx_width-1:0]         last_idx = idx_width'(num_stripes - 1);
   localparam logic [overrun_cnt_width-1:0] cnt_max  = '1;

   state_t     state, state_next;
   logic       vs_meta, vs_sync, vs_dly, vs_rise;
   logic       prev_select, dptr;
   logic [1:0] full, full_next;
   logic       do_start, do_offer, do_accept, do_done, take_comp;
   logic       comp, ovr_evt, sync_evt, last_hit;

   assign vs_rise     = vs_sync & ~vs_dly;
   assign last_hit    = (stripe_index == last_idx);
   assign last_stripe = stripe_valid & last_hit;

   // A completed half is the one the ingester just left; full is sampled before any done clear.
   assign comp     = take_comp & (prev_select != ingester_buffer_select);
   assign ovr_evt  = comp & full[prev_select];
   assign sync_evt = vs_rise & (state != WAIT_FRAME);

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) state <= WAIT_FRAME;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      do_start   = 1'b0;
      do_offer   = 1'b0;
      do_accept  = 1'b0;
      do_done    = 1'b0;
      take_comp  = 1'b0;
      if (vs_rise) begin
         do_start   = 1'b1;
         state_next = FILL;
      end else begin
         case (state)
            WAIT_FRAME: ;
            FILL: begin
               take_comp = 1'b1;
               if (full[dptr]) begin
                  do_offer   = 1'b1;
                  state_next = OFFER;
               end
            end
            OFFER: begin
               take_comp = 1'b1;
               if (stripe_ready) begin
                  do_accept  = 1'b1;
                  state_next = BUSY;
               end
            end
            BUSY: begin
               take_comp = 1'b1;
               if (stripe_done) begin
                  do_done    = 1'b1;
                  state_next = last_hit ? WAIT_FRAME : FILL;
               end
            end
            default: state_next = WAIT_FRAME;
         endcase
      end
   end

   always_comb begin
      full_next = full;
      if (do_done) full_next[dptr] = 1'b0;
      if (comp && !full[prev_select]) full_next[prev_select] = 1'b1;
      if (do_start) full_next = '0;
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         vs_meta       <= 1'b0;
         vs_sync       <= 1'b0;
         vs_dly        <= 1'b0;
         prev_select   <= ingester_buffer_select;
         dptr          <= 1'b0;
         full          <= '0;
         stripe_valid  <= 1'b0;
         stripe_buffer <= 1'b0;
         stripe_index  <= '0;
         frame_start   <= 1'b0;
         frame_done    <= 1'b0;
         overrun       <= 1'b0;
         sync_error    <= 1'b0;
         overrun_count <= '0;
      end else begin
         vs_meta     <= hm01b0_vsync;
         vs_sync     <= vs_meta;
         vs_dly      <= vs_sync;
         prev_select <= ingester_buffer_select;
         full        <= full_next;
         frame_start <= do_start;
         frame_done  <= do_done & last_hit;

         if (do_start) begin
            stripe_index <= '0;
            dptr         <= ingester_buffer_select;
            stripe_valid <= 1'b0;
         end
         if (do_offer) begin
            stripe_valid  <= 1'b1;
            stripe_buffer <= dptr;
         end
         if (do_accept) stripe_valid <= 1'b0;
         if (do_done) begin
            dptr <= ~dptr;
            if (!last_hit) stripe_index <= stripe_index + idx_width'(1);
         end

         // A same-cycle error event takes priority over clear_errors.
         if (clear_errors) begin
            overrun       <= 1'b0;
            sync_error    <= 1'b0;
            overrun_count <= '0;
         end
         if (ovr_evt) begin
            overrun <= 1'b1;
            if (clear_errors)                overrun_count <= overrun_cnt_width'(1);
            else if (overrun_count != cnt_max) overrun_count <= overrun_count + overrun_cnt_width'(1);
         end
         if (sync_evt) sync_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mcu_stripe_scheduler.sv
// Scenario bench for mcu_stripe_scheduler: expected stripes are queued at each ingester
// toggle and compared against the stripes the consumer actually accepts.
module tb_mcu_stripe_scheduler;

   localparam int NS = 4;

   logic       clock = 1'b0;
   logic       nreset = 1'b0;
   logic       hm01b0_vsync = 1'b0;
   logic       ingester_buffer_select = 1'b0;
   logic       stripe_ready = 1'b1;
   logic       stripe_done = 1'b0;
   logic       clear_errors = 1'b0;
   logic       stripe_valid, stripe_buffer, last_stripe;
   logic [1:0] stripe_index;
   logic       frame_start, frame_done, overrun, sync_error;
   logic [7:0] overrun_count;

   int tests = 0;
   int fails = 0;
   int fs_cnt, fd_cnt, done_timer, model_idx;
   bit auto_done;
   logic [3:0] exp_q[$];
   logic [3:0] obs_q[$];

   mcu_stripe_scheduler #(.height_pix(32), .overrun_cnt_width(8)) dut (
      .clock(clock), .nreset(nreset), .hm01b0_vsync(hm01b0_vsync),
      .ingester_buffer_select(ingester_buffer_select), .stripe_ready(stripe_ready),
      .stripe_done(stripe_done), .clear_errors(clear_errors), .stripe_valid(stripe_valid),
      .stripe_buffer(stripe_buffer), .stripe_index(stripe_index), .last_stripe(last_stripe),
      .frame_start(frame_start), .frame_done(frame_done), .overrun(overrun),
      .sync_error(sync_error), .overrun_count(overrun_count)
   );

   always #5 clock = ~clock;

   // One clock; records accepted stripes and pulses, and plays the consumer's done.
   task automatic step();
      logic hs;
      hs = stripe_valid && stripe_ready;
      if (hs) obs_q.push_back({last_stripe, stripe_buffer, stripe_index});
      @(posedge clock);
      #1;
      if (frame_start) fs_cnt++;
      if (frame_done) fd_cnt++;
      if (auto_done) begin
         stripe_done = 1'b0;
         if (hs) done_timer = 10;
         else if (done_timer > 0) begin
            done_timer--;
            if (done_timer == 0) stripe_done = 1'b1;
         end
      end
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic toggle(input bit expect_stripe);
      if (expect_stripe) begin
         exp_q.push_back({model_idx == NS - 1, ingester_buffer_select, 2'(model_idx)});
         model_idx++;
      end
      ingester_buffer_select = ~ingester_buffer_select;
   endtask

   task automatic pulse_vsync();
      model_idx = 0;
      hm01b0_vsync = 1'b1;
      steps(4);
      hm01b0_vsync = 1'b0;
      step();
   endtask

   task automatic apply_reset(input logic sel);
      nreset = 1'b0;
      hm01b0_vsync = 1'b0;
      stripe_ready = 1'b1;
      stripe_done = 1'b0;
      clear_errors = 1'b0;
      ingester_buffer_select = sel;
      auto_done = 1'b1;
      done_timer = 0;
      repeat (3) @(posedge clock);
      #1 nreset = 1'b1;
      steps(2);
      exp_q.delete();
      obs_q.delete();
      fs_cnt = 0;
      fd_cnt = 0;
      model_idx = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clock);
      #1;
      tests++;
      if ({stripe_valid, stripe_buffer, stripe_index, frame_start, frame_done, overrun, sync_error, overrun_count} !== 16'h0) begin
         fails++;
         $display("FAIL reset_outputs: got %h expected 0", {stripe_valid, stripe_buffer, stripe_index, frame_start, frame_done, overrun, sync_error, overrun_count});
      end
      apply_reset(1'b0);
      toggle(0); steps(5);
      toggle(0); steps(5);
      tests++;
      if (stripe_valid !== 1'b0 || obs_q.size() != 0) begin
         fails++;
         $display("FAIL wait_frame_toggle: valid %b accepted %0d expected 0 0", stripe_valid, obs_q.size());
      end
      tests++;
      if (fs_cnt != 0) begin fails++; $display("FAIL no_frame_start: got %0d expected 0", fs_cnt); end
   endtask

   task automatic test_frame();
      logic [3:0] o, e;
      apply_reset(1'b1);
      pulse_vsync();
      steps(10);
      for (int i = 0; i < NS; i++) begin
         toggle(1);
         steps(100);
      end
      tests++;
      if (fs_cnt != 1) begin fails++; $display("FAIL frame_start_cnt: got %0d expected 1", fs_cnt); end
      tests++;
      if (fd_cnt != 1) begin fails++; $display("FAIL frame_done_cnt: got %0d expected 1", fd_cnt); end
      tests++;
      if (overrun !== 1'b0 || sync_error !== 1'b0) begin
         fails++; $display("FAIL frame_errors: got %b%b expected 00", overrun, sync_error);
      end
      tests++;
      if (obs_q.size() != exp_q.size()) begin
         fails++; $display("FAIL frame_stripes: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         tests++;
         if (o !== e) begin fails++; $display("FAIL frame_stripe: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_latency();
      logic [3:0] o, e;
      apply_reset(1'b0);
      pulse_vsync();
      steps(10);
      stripe_ready = 1'b0;
      toggle(1);
      step();
      tests++;
      if (stripe_valid !== 1'b0) begin fails++; $display("FAIL latency_e1: got %b expected 0", stripe_valid); end
      step();
      tests++;
      if (stripe_valid !== 1'b1) begin fails++; $display("FAIL latency_e2: got %b expected 1", stripe_valid); end
      for (int i = 0; i < 5; i++) begin
         step();
         tests++;
         if ({stripe_valid, stripe_buffer, stripe_index} !== 4'b1000) begin
            fails++; $display("FAIL offer_hold: got %b expected 1000", {stripe_valid, stripe_buffer, stripe_index});
         end
      end
      stripe_ready = 1'b1;
      step();
      tests++;
      if (stripe_valid !== 1'b0) begin fails++; $display("FAIL offer_drop: got %b expected 0", stripe_valid); end
      steps(20);
      tests++;
      if (stripe_index !== 2'd1) begin fails++; $display("FAIL latency_advance: got %0d expected 1", stripe_index); end
      tests++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
         fails++; $display("FAIL latency_accept: got %0d expected %0d", obs_q.size(), exp_q.size());
      end else begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         tests++;
         if (o !== e) begin fails++; $display("FAIL latency_stripe: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_overrun();
      logic [3:0] o, e;
      apply_reset(1'b0);
      pulse_vsync();
      steps(10);
      auto_done = 1'b0;
      toggle(1); steps(10);
      toggle(1); steps(5);
      tests++;
      if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_early: got %b expected 0", overrun); end
      toggle(0); steps(5);
      tests++;
      if (overrun !== 1'b1 || overrun_count !== 8'd1) begin
         fails++; $display("FAIL overrun_set: got %b/%0d expected 1/1", overrun, overrun_count);
      end
      tests++;
      if (stripe_index !== 2'd0) begin fails++; $display("FAIL overrun_index: got %0d expected 0", stripe_index); end
      stripe_done = 1'b1;
      step();
      stripe_done = 1'b0;
      steps(10);
      tests++;
      if (obs_q.size() != exp_q.size()) begin
         fails++; $display("FAIL overrun_stripes: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         tests++;
         if (o !== e) begin fails++; $display("FAIL overrun_stripe: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_saturate();
      apply_reset(1'b1);
      pulse_vsync();
      steps(10);
      auto_done = 1'b0;
      toggle(1); steps(10);
      repeat (310) begin
         toggle(0);
         step();
      end
      tests++;
      if (overrun_count !== 8'd255 || overrun !== 1'b1) begin
         fails++; $display("FAIL overrun_saturate: got %b/%0d expected 1/255", overrun, overrun_count);
      end
      clear_errors = 1'b1;
      step();
      clear_errors = 1'b0;
      tests++;
      if (overrun_count !== 8'd0 || overrun !== 1'b0) begin
         fails++; $display("FAIL overrun_clear: got %b/%0d expected 0/0", overrun, overrun_count);
      end
      steps(2);
      clear_errors = 1'b1;
      toggle(0);
      step();
      clear_errors = 1'b0;
      tests++;
      if (overrun_count !== 8'd1 || overrun !== 1'b1) begin
         fails++; $display("FAIL clear_vs_overrun: got %b/%0d expected 1/1", overrun, overrun_count);
      end
   endtask

   task automatic test_sync_error();
      logic [3:0] o, e;
      apply_reset(1'b0);
      pulse_vsync();
      steps(10);
      toggle(1); steps(100);
      toggle(1); steps(100);
      toggle(1); steps(3);
      tests++;
      if (sync_error !== 1'b0) begin fails++; $display("FAIL sync_early: got %b expected 0", sync_error); end
      pulse_vsync();
      tests++;
      if (sync_error !== 1'b1 || fs_cnt != 2) begin
         fails++; $display("FAIL sync_set: got %b/%0d expected 1/2", sync_error, fs_cnt);
      end
      tests++;
      if (stripe_index !== 2'd0) begin fails++; $display("FAIL sync_index: got %0d expected 0", stripe_index); end
      steps(20);
      tests++;
      if (stripe_index !== 2'd0 || stripe_valid !== 1'b0 || fd_cnt != 0) begin
         fails++; $display("FAIL stale_done: got idx %0d valid %b done %0d expected 0 0 0", stripe_index, stripe_valid, fd_cnt);
      end
      for (int i = 0; i < NS; i++) begin
         toggle(1);
         steps(100);
      end
      tests++;
      if (fd_cnt != 1) begin fails++; $display("FAIL sync_next_frame: got %0d expected 1", fd_cnt); end
      tests++;
      if (obs_q.size() != exp_q.size()) begin
         fails++; $display("FAIL sync_stripes: got %0d expected %0d", obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         tests++;
         if (o !== e) begin fails++; $display("FAIL sync_stripe: got %h expected %h", o, e); end
      end
   endtask

   task automatic test_reset_mid();
      int valid_seen;
      apply_reset(1'b0);
      pulse_vsync();
      steps(10);
      stripe_ready = 1'b0;
      toggle(1);
      steps(3);
      tests++;
      if (stripe_valid !== 1'b1) begin fails++; $display("FAIL pre_reset_offer: got %b expected 1", stripe_valid); end
      #2 nreset = 1'b0;
      #1;
      tests++;
      if (stripe_valid !== 1'b0 || frame_start !== 1'b0 || frame_done !== 1'b0) begin
         fails++; $display("FAIL async_reset: got %b%b%b expected 000", stripe_valid, frame_start, frame_done);
      end
      #2 nreset = 1'b1;
      fs_cnt = 0;
      valid_seen = 0;
      repeat (4) begin
         toggle(0);
         repeat (5) begin
            step();
            if (stripe_valid) valid_seen++;
         end
      end
      tests++;
      if (valid_seen != 0 || fs_cnt != 0) begin
         fails++; $display("FAIL post_reset_idle: got valid %0d starts %0d expected 0 0", valid_seen, fs_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_latency();
      test_overrun();
      test_saturate();
      test_sync_error();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
